// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the soft processor decode path.
//   - Opcode encodings (OP_ADD .. OP_NOP).
//   - Instruction field positions.
//   - The ID/EX bundle struct.
//   - Register-read decode helpers (reads_rs / reads_rt / reads_rd) and an
//     opcode legality check. The forwarding unit reuses the read helpers.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Opcode encodings
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LDR  = 4'h5;
    localparam logic [3:0] OP_STR  = 4'h6;
    localparam logic [3:0] OP_B    = 4'h8;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Field positions inside the 32-bit instruction word
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 28;
    localparam int RD_MSB    = 27;
    localparam int RD_LSB    = 24;
    localparam int RS_MSB    = 23;
    localparam int RS_LSB    = 20;
    localparam int RT_MSB    = 19;
    localparam int RT_LSB    = 16;
    localparam int IMM16_MSB = 15;
    localparam int IMM24_MSB = 23;

    // Decoded bundle held in the ID/EX register
    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [31:0] imm;
        logic        sel_ext;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
    } idex_t;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_LDR, OP_STR, OP_B, OP_NOP: is_legal = 1'b1;
            default:                               is_legal = 1'b0;
        endcase
    endfunction

    // Undefined opcodes decode as NOP, so they read nothing.
    function automatic logic reads_rs(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_LDR, OP_STR: reads_rs = 1'b1;
            default:                 reads_rs = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: reads_rt = 1'b1;
            default:                       reads_rt = 1'b0;
        endcase
    endfunction

    // STR reads rd as the store-data source.
    function automatic logic reads_rd(input logic [3:0] op);
        reads_rd = (op == OP_STR);
    endfunction

endpackage

// File: rtl/immExt.sv
// -----------------------------------------------------------------------------
// immExt
// Immediate extender. Zero-extends either the 24-bit or the 16-bit immediate
// to 32 bits.
// Ports:
//   imm16_i   [15:0]  short immediate (I-type)
//   imm24_i   [23:0]  long immediate (B-type)
//   sel_ext_i         1 selects imm24, 0 selects imm16
//   imm_o     [31:0]  zero-extended immediate
// -----------------------------------------------------------------------------
module immExt (
    input  logic [15:0] imm16_i,
    input  logic [23:0] imm24_i,
    input  logic        sel_ext_i,
    output logic [31:0] imm_o
);

    assign imm_o = sel_ext_i ? {8'b0, imm24_i} : {16'b0, imm16_i};

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Instruction decode stage: slices the fetched instruction, decodes control
// bits, extends the immediate and registers the bundle into ID/EX. Inserts a
// one-cycle bubble on a load-use hazard and honours flushes.
//
// Handshake: a transfer on either side occurs on a rising edge where the
// producer's valid and the consumer's ready are both high. if_ready is a
// function of ID/EX state, ex_ready, flush and if_instr only -- never of
// if_valid. Fetch holds if_instr stable while if_valid & ~if_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_instr        instruction offered by fetch
//   if_ready                 decode accepts if_instr this cycle
//   ex_ready                 execute consumes ID/EX this cycle
//   flush                    kill ID/EX and the offered instruction
//   ex_valid                 ID/EX holds a real instruction
//   ex_opcode/rd/rs/rt/imm   decoded fields
//   ex_sel_ext               1 = imm24 was used, 0 = imm16
//   ex_reg_we/mem_rd/mem_wr/branch  control bits
//   illegal                  one-cycle pulse with an accepted undefined opcode
//   stall_cnt                saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module decode_stage
    import cpu_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    output logic                   if_ready,
    input  logic                   ex_ready,
    input  logic                   flush,
    output logic                   ex_valid,
    output logic [3:0]             ex_opcode,
    output logic [3:0]             ex_rd,
    output logic [3:0]             ex_rs,
    output logic [3:0]             ex_rt,
    output logic [31:0]            ex_imm,
    output logic                   ex_sel_ext,
    output logic                   ex_reg_we,
    output logic                   ex_mem_rd,
    output logic                   ex_mem_wr,
    output logic                   ex_branch,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // ---------------------------------------------------------------------
    // Field slicing
    // ---------------------------------------------------------------------
    logic [3:0]  op_w;
    logic [3:0]  rd_w;
    logic [3:0]  rs_w;
    logic [3:0]  rt_w;
    logic [15:0] imm16_w;
    logic [23:0] imm24_w;

    assign op_w    = if_instr[OPC_MSB:OPC_LSB];
    assign rd_w    = if_instr[RD_MSB:RD_LSB];
    assign rs_w    = if_instr[RS_MSB:RS_LSB];
    assign rt_w    = if_instr[RT_MSB:RT_LSB];
    assign imm16_w = if_instr[IMM16_MSB:0];
    assign imm24_w = if_instr[IMM24_MSB:0];

    // ---------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------
    logic        sel_ext_w;
    logic        reg_we_w;
    logic        mem_rd_w;
    logic        mem_wr_w;
    logic        branch_w;
    logic        illegal_w;
    logic [31:0] imm_w;

    always_comb begin
        sel_ext_w = 1'b0;
        reg_we_w  = 1'b0;
        mem_rd_w  = 1'b0;
        mem_wr_w  = 1'b0;
        branch_w  = 1'b0;
        case (op_w)
            OP_ADD, OP_SUB, OP_AND, OP_OR: reg_we_w = 1'b1;
            OP_ADDI:                       reg_we_w = 1'b1;
            OP_LDR: begin
                reg_we_w = 1'b1;
                mem_rd_w = 1'b1;
            end
            OP_STR:                        mem_wr_w = 1'b1;
            OP_B: begin
                sel_ext_w = 1'b1;
                branch_w  = 1'b1;
            end
            default: ;                     // NOP and undefined: all zero
        endcase
    end

    assign illegal_w = ~is_legal(op_w);

    immExt u_imm_ext (
        .imm16_i   (imm16_w),
        .imm24_i   (imm24_w),
        .sel_ext_i (sel_ext_w),
        .imm_o     (imm_w)
    );

    idex_t dec_w;

    always_comb begin
        dec_w         = '0;
        dec_w.opcode  = op_w;
        dec_w.rd      = rd_w;
        dec_w.rs      = rs_w;
        dec_w.rt      = rt_w;
        dec_w.imm     = imm_w;
        dec_w.sel_ext = sel_ext_w;
        dec_w.reg_we  = reg_we_w;
        dec_w.mem_rd  = mem_rd_w;
        dec_w.mem_wr  = mem_wr_w;
        dec_w.branch  = branch_w;
    end

    // ---------------------------------------------------------------------
    // ID/EX register state
    // ---------------------------------------------------------------------
    idex_t                  idex_q;
    logic                   valid_q;
    logic                   illegal_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // ---------------------------------------------------------------------
    // Hazard / advance
    // ---------------------------------------------------------------------
    logic adv_w;
    logic uses_ex_rd_w;
    logic hazard_w;
    logic xfer_w;

    assign adv_w = ~valid_q | ex_ready;

    // Only fields the incoming instruction actually reads can collide with
    // the load destination; the offered word is examined regardless of
    // if_valid so that if_ready stays independent of if_valid.
    assign uses_ex_rd_w = (reads_rs(op_w) && (rs_w == idex_q.rd))
                        | (reads_rt(op_w) && (rt_w == idex_q.rd))
                        | (reads_rd(op_w) && (rd_w == idex_q.rd));

    assign hazard_w = valid_q && (idex_q.opcode == OP_LDR) && uses_ex_rd_w;
    assign if_ready = adv_w & ~hazard_w & ~flush;
    assign xfer_w   = if_valid & if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (adv_w && xfer_w) begin
            idex_q    <= dec_w;
            valid_q   <= 1'b1;
            illegal_q <= illegal_w;
        end else if (adv_w) begin
            // Bubble: payload is left as-is, only the valid bit drops.
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (hazard_w && if_valid && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            // Held by execute; illegal is a single-cycle pulse.
            illegal_q <= 1'b0;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_opcode  = idex_q.opcode;
    assign ex_rd      = idex_q.rd;
    assign ex_rs      = idex_q.rs;
    assign ex_rt      = idex_q.rt;
    assign ex_imm     = idex_q.imm;
    assign ex_sel_ext = idex_q.sel_ext;
    assign ex_reg_we  = idex_q.reg_we;
    assign ex_mem_rd  = idex_q.mem_rd;
    assign ex_mem_wr  = idex_q.mem_wr;
    assign ex_branch  = idex_q.branch;
    assign illegal    = illegal_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage. Inputs change 1 time unit after the rising
// edge; outputs are checked at that point (registered values settled).
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic          if_ready;
    logic          ex_ready;
    logic          flush;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [3:0]    ex_rd;
    logic [3:0]    ex_rs;
    logic [3:0]    ex_rt;
    logic [31:0]   ex_imm;
    logic          ex_sel_ext;
    logic          ex_reg_we;
    logic          ex_mem_rd;
    logic          ex_mem_wr;
    logic          ex_branch;
    logic          illegal;
    logic [W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    decode_stage #(.STALL_CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .ex_ready   (ex_ready),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_rd      (ex_rd),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_imm     (ex_imm),
        .ex_sel_ext (ex_sel_ext),
        .ex_reg_we  (ex_reg_we),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_branch  (ex_branch),
        .illegal    (illegal),
        .stall_cnt  (stall_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr);
        if_valid = 1'b1;
        if_instr = instr;
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'h0;
        ex_ready = 1'b1;
        flush    = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_ex_imm", ex_imm, 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_if_ready", 32'(if_ready), 32'h1);

        // ---- ADDI then B, straight line ----
        offer(32'h4120_0005);
        chk("addi_if_ready", 32'(if_ready), 32'h1);
        tick();
        chk("addi_valid", 32'(ex_valid), 32'h1);
        chk("addi_opcode", 32'(ex_opcode), 32'h4);
        chk("addi_rd", 32'(ex_rd), 32'h1);
        chk("addi_rs", 32'(ex_rs), 32'h2);
        chk("addi_imm", ex_imm, 32'h0000_0005);
        chk("addi_sel_ext", 32'(ex_sel_ext), 32'h0);
        chk("addi_reg_we", 32'(ex_reg_we), 32'h1);
        offer(32'h8000_1234);
        chk("b_if_ready", 32'(if_ready), 32'h1);
        tick();
        chk("b_valid", 32'(ex_valid), 32'h1);
        chk("b_imm", ex_imm, 32'h0000_1234);
        chk("b_sel_ext", 32'(ex_sel_ext), 32'h1);
        chk("b_branch", 32'(ex_branch), 32'h1);
        chk("b_reg_we", 32'(ex_reg_we), 32'h0);
        idle();
        chk("b_if_ready_after", 32'(if_ready), 32'h1);
        tick();
        chk("drain_valid", 32'(ex_valid), 32'h0);

        // ---- LDR r3 then ADD r1 = r3 + r2: one bubble ----
        offer(32'h5310_0000);
        tick();
        chk("ldr_valid", 32'(ex_valid), 32'h1);
        chk("ldr_mem_rd", 32'(ex_mem_rd), 32'h1);
        chk("ldr_rd", 32'(ex_rd), 32'h3);
        offer(32'h0132_0000);
        chk("hz_if_ready", 32'(if_ready), 32'h0);
        tick();
        chk("hz_bubble_valid", 32'(ex_valid), 32'h0);
        chk("hz_stall_cnt", 32'(stall_cnt), 32'h1);
        chk("hz_if_ready_next", 32'(if_ready), 32'h1);
        tick();
        chk("hz_add_valid", 32'(ex_valid), 32'h1);
        chk("hz_add_opcode", 32'(ex_opcode), 32'h0);
        chk("hz_add_rs", 32'(ex_rs), 32'h3);
        chk("hz_add_rt", 32'(ex_rt), 32'h2);
        idle();
        tick();

        // ---- LDR r3 then ADD r1 = r4 + r5: no bubble ----
        offer(32'h5310_0000);
        tick();
        offer(32'h0145_0000);
        chk("nohz_if_ready", 32'(if_ready), 32'h1);
        tick();
        chk("nohz_valid", 32'(ex_valid), 32'h1);
        chk("nohz_opcode", 32'(ex_opcode), 32'h0);
        chk("nohz_rs", 32'(ex_rs), 32'h4);
        chk("nohz_stall_cnt", 32'(stall_cnt), 32'h1);

        // ---- ex_ready low for 3 cycles: hold ----
        ex_ready = 1'b0;
        offer(32'h3567_0000);
        for (int i = 0; i < 3; i++) begin
            chk("hold_if_ready", 32'(if_ready), 32'h0);
            tick();
            chk("hold_valid", 32'(ex_valid), 32'h1);
            chk("hold_opcode", 32'(ex_opcode), 32'h0);
            chk("hold_rs", 32'(ex_rs), 32'h4);
        end
        ex_ready = 1'b1;
        #1;
        chk("release_if_ready", 32'(if_ready), 32'h1);
        tick();
        chk("release_opcode", 32'(ex_opcode), 32'h3);
        chk("release_rd", 32'(ex_rd), 32'h5);
        chk("release_rt", 32'(ex_rt), 32'h7);

        // ---- flush with if_valid and ex_ready low ----
        ex_ready = 1'b0;
        flush    = 1'b1;
        offer(32'h4AB0_0077);
        chk("flush_if_ready", 32'(if_ready), 32'h0);
        tick();
        flush    = 1'b0;
        ex_ready = 1'b1;
        chk("flush_valid", 32'(ex_valid), 32'h0);
        chk("flush_not_accepted", 32'(ex_rd), 32'h5);
        chk("flush_stall_cnt", 32'(stall_cnt), 32'h1);

        // ---- undefined opcode 0xA ----
        offer(32'hA123_4567);
        chk("illegal_if_ready", 32'(if_ready), 32'h1);
        tick();
        chk("illegal_pulse", 32'(illegal), 32'h1);
        chk("illegal_valid", 32'(ex_valid), 32'h1);
        chk("illegal_opcode", 32'(ex_opcode), 32'hA);
        chk("illegal_ctrl", {28'h0, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch}, 32'h0);
        chk("illegal_imm", ex_imm, 32'h0000_4567);
        idle();
        tick();
        chk("illegal_drop", 32'(illegal), 32'h0);

        // ---- LDR r3 then STR whose data register is r3 ----
        offer(32'h5310_0000);
        tick();
        offer(32'h6300_0000);
        chk("str_hz_if_ready", 32'(if_ready), 32'h0);
        tick();
        chk("str_hz_bubble", 32'(ex_valid), 32'h0);
        chk("str_hz_stall_cnt", 32'(stall_cnt), 32'h2);
        tick();
        chk("str_valid", 32'(ex_valid), 32'h1);
        chk("str_mem_wr", 32'(ex_mem_wr), 32'h1);
        chk("str_reg_we", 32'(ex_reg_we), 32'h0);

        // ---- reset mid-stream ----
        offer(32'h4120_0005);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("mid_rst_valid", 32'(ex_valid), 32'h0);
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("mid_rst_imm", ex_imm, 32'h0);
        chk("mid_rst_opcode", 32'(ex_opcode), 32'h0);
        chk("mid_rst_rd", 32'(ex_rd), 32'h0);
        chk("mid_rst_if_ready", 32'(if_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
